// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared definitions for the Sobel frame engine:
//     state_t          - pass-sequencer states
//     NBR_DX / NBR_DY  - order in which the 8 neighbours of a pixel are read
//                        (TL, T, TR, L, R, BL, B, BR)
//     KX_W / KY_W      - Sobel kernel weights for gx / gy, in the same order
package sobel_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      DRAIN = 3'd2,
      OUT   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int NBR_CNT = 8;

   localparam logic signed [1:0] NBR_DX [NBR_CNT] =
      '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
   localparam logic signed [1:0] NBR_DY [NBR_CNT] =
      '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

   localparam logic signed [2:0] KX_W [NBR_CNT] =
      '{-3'sd1, 3'sd0, 3'sd1, -3'sd2, 3'sd2, -3'sd1, 3'sd0, 3'sd1};
   localparam logic signed [2:0] KY_W [NBR_CNT] =
      '{-3'sd1, -3'sd2, -3'sd1, 3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd1};

endpackage

// File: rtl/sobel_if.sv
// sobel_if
//   Result stream of the Sobel frame engine (valid/ready handshake).
//     out_valid  - result available (driven by master)
//     out_ready  - consumer accepts the result (driven by slave)
//     out_addr   - raster address of the result pixel
//     out_gx/gy  - signed gradients, PIX_W+3 bits
//     out_data   - magnitude or binary edge value
//   Modports: master (engine side), slave (consumer side).
interface sobel_if
   import sobel_pkg::*;
#(
   parameter int AW    = 10,
   parameter int PIX_W = 12
) ();

   logic                    out_valid;
   logic                    out_ready;
   logic [AW-1:0]           out_addr;
   logic signed [PIX_W+2:0] out_gx;
   logic signed [PIX_W+2:0] out_gy;
   logic [PIX_W-1:0]        out_data;

   modport master (
      output out_valid, out_addr, out_gx, out_gy, out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_addr, out_gx, out_gy, out_data,
      output out_ready
   );

endinterface

// File: rtl/sobel_frame_ram.sv
// sobel_frame_ram
//   Frame buffer: DEPTH x PIX_W, one write port, one read port with a
//   registered (1-cycle latency) read. Contents are never cleared.
//     clk    - rising-edge clock
//     we     - write strobe
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address
//     rdata  - read data, valid the cycle after raddr is presented
module sobel_frame_ram
   import sobel_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int PIX_W = 12
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [PIX_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem_q [DEPTH];
   logic [PIX_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sobel_frame_engine.sv
// sobel_frame_engine
//   Stores one IMG_W x IMG_H frame and, on start, streams one Sobel result
//   per pixel in raster order over a valid/ready interface.
//     clk, rst          - clock, synchronous active-high reset
//     wr_en/addr/data   - frame-buffer write port (accepted only when idle)
//     start             - begins a frame pass (ignored unless idle)
//     thresh            - edge threshold (only with SOBEL_THRESH_EN)
//     busy              - pass in progress
//     done              - one-cycle pulse after the last result transfers
//     out_if            - result stream (sobel_if.master)
//   Build option: define SOBEL_THRESH_EN to output a binary edge map
//   (all-ones when magnitude >= thresh) instead of the magnitude.
module sobel_frame_engine
   import sobel_pkg::*;
#(
   parameter int  IMG_W = 32,
   parameter int  IMG_H = 32,
   parameter int  PIX_W = 12,
   localparam int AW    = $clog2(IMG_W*IMG_H)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             start,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0] thresh,
`endif
   output logic             busy,
   output logic             done,
   sobel_if.master          out_if
);

   localparam int GW = PIX_W + 3;
   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
   localparam logic [AW-1:0] PIX_LAST = AW'(IMG_W*IMG_H - 1);

   // Pixel scaled by a kernel weight in {-2,-1,0,1,2}.
   function automatic logic signed [GW-1:0] weigh(input logic signed [2:0] w,
                                                  input logic [PIX_W-1:0] p);
      logic signed [GW-1:0] pe;
      pe = $signed({3'b000, p});
      case (w)
         3'sd1:   weigh = pe;
         -3'sd1:  weigh = -pe;
         3'sd2:   weigh = pe <<< 1;
         -3'sd2:  weigh = -(pe <<< 1);
         default: weigh = '0;
      endcase
   endfunction

   // |gx|+|gy| clamped to the pixel range.
   function automatic logic [PIX_W-1:0] sat_mag(input logic signed [GW-1:0] gx,
                                                input logic signed [GW-1:0] gy);
      logic [GW-1:0] ax;
      logic [GW-1:0] ay;
      logic [GW:0]   sum;
      ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
      sum = {1'b0, ax} + {1'b0, ay};
      if (|sum[GW:PIX_W]) begin
         sat_mag = '1;
      end else begin
         sat_mag = sum[PIX_W-1:0];
      end
   endfunction

   function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
   endfunction

   state_t                  state_q, state_d;
   logic [AW-1:0]           pix_q, pix_d;
   logic [XW-1:0]           x_q, x_d;
   logic [YW-1:0]           y_q, y_d;
   logic [2:0]              nbr_q, nbr_d;
   logic signed [GW-1:0]    gx_acc_q, gx_acc_d;
   logic signed [GW-1:0]    gy_acc_q, gy_acc_d;
   logic [AW-1:0]           out_addr_q, out_addr_d;
   logic signed [GW-1:0]    out_gx_q, out_gx_d;
   logic signed [GW-1:0]    out_gy_q, out_gy_d;
   logic [PIX_W-1:0]        out_data_q, out_data_d;

   logic [AW-1:0]           row_base;
   logic [AW-1:0]           rd_addr;
   logic [PIX_W-1:0]        rd_data;
   logic                    ram_we;
   logic [XW-1:0]           nx;
   logic [YW-1:0]           ny;
   logic                    cur_border;
   logic                    next_border;
   logic signed [GW-1:0]    gx_fin;
   logic signed [GW-1:0]    gy_fin;
   logic [PIX_W-1:0]        mag;
   logic [PIX_W-1:0]        data_fin;

   // The buffer is frozen while a pass runs so a pass always sees one frame.
   assign ram_we = wr_en && (state_q == IDLE);

   sobel_frame_ram #(
      .DEPTH (IMG_W*IMG_H),
      .AW    (AW),
      .PIX_W (PIX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Neighbour address for the current read slot; only used for interior
   // pixels, so no wrap-around handling is needed.
   always_comb begin
      row_base = pix_q;
      if (NBR_DY[nbr_q] == -2'sd1) begin
         row_base = pix_q - AW'(IMG_W);
      end else if (NBR_DY[nbr_q] == 2'sd1) begin
         row_base = pix_q + AW'(IMG_W);
      end
      rd_addr = row_base;
      if (NBR_DX[nbr_q] == -2'sd1) begin
         rd_addr = row_base - AW'(1);
      end else if (NBR_DX[nbr_q] == 2'sd1) begin
         rd_addr = row_base + AW'(1);
      end
   end

   always_comb begin
      nx          = (x_q == X_LAST) ? '0 : x_q + XW'(1);
      ny          = (x_q == X_LAST) ? y_q + YW'(1) : y_q;
      cur_border  = is_border(x_q, y_q);
      next_border = is_border(nx, ny);
   end

   // Final gradients fold in the last neighbour, which arrives during DRAIN.
   always_comb begin
      gx_fin = gx_acc_q + weigh(KX_W[NBR_CNT-1], rd_data);
      gy_fin = gy_acc_q + weigh(KY_W[NBR_CNT-1], rd_data);
      mag    = sat_mag(gx_fin, gy_fin);
`ifdef SOBEL_THRESH_EN
      data_fin = (mag >= thresh) ? '1 : '0;
`else
      data_fin = mag;
`endif
   end

   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      x_d        = x_q;
      y_d        = y_q;
      nbr_d      = nbr_q;
      gx_acc_d   = gx_acc_q;
      gy_acc_d   = gy_acc_q;
      out_addr_d = out_addr_q;
      out_gx_d   = out_gx_q;
      out_gy_d   = out_gy_q;
      out_data_d = out_data_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = FETCH;
               pix_d    = '0;
               x_d      = '0;
               y_d      = '0;
               nbr_d    = '0;
               gx_acc_d = '0;
               gy_acc_d = '0;
            end
         end

         FETCH: begin
            // Only pixel 0 (always border) can arrive here as a border pixel;
            // it leaves after one cycle without issuing reads.
            if (cur_border) begin
               state_d    = OUT;
               out_addr_d = pix_q;
               out_gx_d   = '0;
               out_gy_d   = '0;
               out_data_d = '0;
            end else begin
               // Read data lags the address by one slot.
               if (nbr_q != 3'd0) begin
                  gx_acc_d = gx_acc_q + weigh(KX_W[nbr_q - 3'd1], rd_data);
                  gy_acc_d = gy_acc_q + weigh(KY_W[nbr_q - 3'd1], rd_data);
               end
               nbr_d = nbr_q + 3'd1;
               if (nbr_q == 3'(NBR_CNT - 1)) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            state_d    = OUT;
            out_addr_d = pix_q;
            out_gx_d   = gx_fin;
            out_gy_d   = gy_fin;
            out_data_d = data_fin;
         end

         OUT: begin
            if (out_if.out_ready) begin
               if (pix_q == PIX_LAST) begin
                  state_d = DONE;
               end else begin
                  pix_d = pix_q + AW'(1);
                  x_d   = nx;
                  y_d   = ny;
                  if (next_border) begin
                     out_addr_d = pix_q + AW'(1);
                     out_gx_d   = '0;
                     out_gy_d   = '0;
                     out_data_d = '0;
                  end else begin
                     state_d  = FETCH;
                     nbr_d    = '0;
                     gx_acc_d = '0;
                     gy_acc_d = '0;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         nbr_q      <= '0;
         out_addr_q <= '0;
         out_gx_q   <= '0;
         out_gy_q   <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         x_q        <= x_d;
         y_q        <= y_d;
         nbr_q      <= nbr_d;
         out_addr_q <= out_addr_d;
         out_gx_q   <= out_gx_d;
         out_gy_q   <= out_gy_d;
         out_data_q <= out_data_d;
      end
   end

   // Accumulators are cleared whenever a new pixel starts, so they need no reset.
   always_ff @(posedge clk) begin
      gx_acc_q <= gx_acc_d;
      gy_acc_q <= gy_acc_d;
   end

   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign out_if.out_valid = (state_q == OUT);
   assign out_if.out_addr  = out_addr_q;
   assign out_if.out_gx    = out_gx_q;
   assign out_if.out_gy    = out_gy_q;
   assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_sobel_frame_engine.sv
// tb_sobel_frame_engine
//   Scoreboard bench for sobel_frame_engine (32x32, 12-bit pixels).
//   The stimulus side loads frames, computes every expected result from the
//   frame with plain Sobel arithmetic and queues it before starting a pass;
//   an independent monitor pops and compares each transferred result.
//   Define SOBEL_THRESH_EN to exercise the thresholded build (thresh = 400).
module tb_sobel_frame_engine;

   localparam int W   = 32;
   localparam int H   = 32;
   localparam int N   = W * H;
   localparam int PW  = 12;
   localparam int MAXV = 4095;
   localparam int THR = 400;
`ifdef SOBEL_THRESH_EN
   localparam int VE_DATA = MAXV;
`else
   localparam int VE_DATA = 400;
`endif

   typedef struct {
      int addr;
      int gx;
      int gy;
      int data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [9:0]    wr_addr;
   logic [PW-1:0] wr_data;
   logic          start;
   logic          busy;
   logic          done;
`ifdef SOBEL_THRESH_EN
   logic [PW-1:0] thresh = PW'(THR);
`endif

   sobel_if #(.AW(10), .PIX_W(PW)) oif ();

   sobel_frame_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
`ifdef SOBEL_THRESH_EN
      .thresh  (thresh),
`endif
      .busy    (busy),
      .done    (done),
      .out_if  (oif)
   );

   always #5 clk = ~clk;

   int   img [N];
   exp_t q [$];
   int   spot_gx [int];
   int   spot_data [int];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   n_popped = 0;
   int   stall_cycles = 0;
   int   rdy_mode = 0;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int px(input int x, input int y);
      return img[y*W + x];
   endfunction

   // Reference: Sobel on the whole frame, border pixels produce zeros.
   task automatic push_expected();
      exp_t e;
      int   mag;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            e.addr = y*W + x;
            e.gx = 0;
            e.gy = 0;
            e.data = 0;
            if (x > 0 && x < W-1 && y > 0 && y < H-1) begin
               e.gx = (px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1))
                    - (px(x-1,y-1) + 2*px(x-1,y) + px(x-1,y+1));
               e.gy = (px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1))
                    - (px(x-1,y-1) + 2*px(x,y-1) + px(x+1,y-1));
               mag = iabs(e.gx) + iabs(e.gy);
               if (mag > MAXV) mag = MAXV;
`ifdef SOBEL_THRESH_EN
               e.data = (mag >= THR) ? MAXV : 0;
`else
               e.data = mag;
`endif
            end
            q.push_back(e);
         end
      end
   endtask

   // kind: 0 uniform 100, 1 vertical edge, 2 left 4095 / right 0, 3 random
   task automatic load_frame(input int kind);
      int v;
      for (int a = 0; a < N; a++) begin
         case (kind)
            0:       v = 100;
            1:       v = ((a % W) < 16) ? 0 : 100;
            2:       v = ((a % W) < 16) ? MAXV : 0;
            default: v = int'($urandom_range(0, MAXV));
         endcase
         img[a] = v;
         @(posedge clk); #1;
         wr_en   = 1'b1;
         wr_addr = 10'(a);
         wr_data = PW'(v);
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},  int'(busy), 0);
      chk({tag, "_valid"}, int'(oif.out_valid), 0);
      chk({tag, "_done"},  int'(done), 0);
      chk({tag, "_addr"},  int'(oif.out_addr), 0);
      chk({tag, "_gx"},    int'(oif.out_gx), 0);
      chk({tag, "_gy"},    int'(oif.out_gy), 0);
      chk({tag, "_data"},  int'(oif.out_data), 0);
   endtask

   task automatic start_pulse();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
   endtask

   task automatic run_pass(input bit disturb);
      int d0;
      int cyc;
      int s0;
      push_expected();
      d0 = done_cnt;
      n_popped = 0;
      start_pulse();
      if (disturb) begin
         cyc = 0;
         while (!oif.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("valid_seen", int'(oif.out_valid), 1);
         s0 = stall_cycles;
         rdy_mode = 2;
         repeat (5) @(posedge clk);
         #1;
         rdy_mode = 1;
         chk("stall_held", int'((stall_cycles - s0) >= 5), 1);
         // Writes and a stray start while busy must have no effect.
         for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'($urandom_range(0, N-1));
            wr_data = PW'($urandom);
            start   = (i == 4);
            @(posedge clk); #1;
         end
         wr_en = 1'b0;
         start = 1'b0;
         chk("busy_during_writes", int'(busy), 1);
      end
      cyc = 0;
      while (done_cnt == d0 && cyc < 40000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("pass_finished", int'(done_cnt != d0), 1);
      chk("busy_low_after_done", int'(busy), 0);
      chk("results_left", q.size(), 0);
      chk("results_seen", n_popped, N);
      repeat (3) @(posedge clk);
      #1;
      chk("single_done", done_cnt - d0, 1);
      q.delete();
   endtask

   // out_ready driver: 0 always ready, 1 random (75%), 2 held low
   initial begin
      oif.out_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         case (rdy_mode)
            0:       oif.out_ready = 1'b1;
            1:       oif.out_ready = ($urandom_range(0, 3) != 0);
            default: oif.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      exp_t it;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (done) done_cnt++;
            if (oif.out_valid) begin
               chk("valid_only_when_busy", int'(busy), 1);
               if (q.size() == 0) begin
                  chk("unexpected_result_addr", int'(oif.out_addr), -1);
               end else if (oif.out_ready) begin
                  it = q.pop_front();
                  n_popped++;
                  chk("addr", int'(oif.out_addr), it.addr);
                  chk("gx",   int'(oif.out_gx),   it.gx);
                  chk("gy",   int'(oif.out_gy),   it.gy);
                  chk("data", int'(oif.out_data), it.data);
                  if (spot_gx.exists(it.addr)) begin
                     chk("spot_gx",   int'(oif.out_gx),   spot_gx[it.addr]);
                     chk("spot_data", int'(oif.out_data), spot_data[it.addr]);
                  end
               end else begin
                  stall_cycles++;
                  chk("held_addr", int'(oif.out_addr), q[0].addr);
                  chk("held_gx",   int'(oif.out_gx),   q[0].gx);
                  chk("held_data", int'(oif.out_data), q[0].data);
               end
            end
         end
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int cyc;
      rst = 1'b1;
      start = 1'b0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Uniform frame, always ready: all zeros
      rdy_mode = 0;
      load_frame(0);
      run_pass(1'b0);

      // Vertical edge, random backpressure
      rdy_mode = 1;
      load_frame(1);
      spot_gx[5*W+15] = 400;  spot_data[5*W+15] = VE_DATA;
      spot_gx[5*W+16] = 400;  spot_data[5*W+16] = VE_DATA;
      spot_gx[5*W+10] = 0;    spot_data[5*W+10] = 0;
      run_pass(1'b0);
      spot_gx.delete();
      spot_data.delete();

      // Saturating edge
      load_frame(2);
      spot_gx[5*W+15] = -16380;  spot_data[5*W+15] = MAXV;
      run_pass(1'b0);
      spot_gx.delete();
      spot_data.delete();

      // Random frame with stall, busy writes and stray start
      load_frame(3);
      run_pass(1'b1);

      // Abort mid-pass, then rerun on the untouched frame
      push_expected();
      d0 = done_cnt;
      n_popped = 0;
      start_pulse();
      cyc = 0;
      while (n_popped < 300 && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reached_pixel_300", int'(n_popped >= 300), 1);
      rdy_mode = 2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      rdy_mode = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt - d0, 0);
      run_pass(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
